// File: rtl/conv_pkg.sv
// Constants shared between the conv-2D adder stage and the result serializer.
package conv_pkg;
  localparam int bitsize    = 14;
  localparam int NUM_CH     = 16;
  localparam int CH_W       = $clog2(NUM_CH);
  localparam int NUM_PIXELS = 12544;
  localparam int ADDR_W     = 14;
  localparam int FIFO_DEPTH = 2;
  localparam int VEC_W      = bitsize * NUM_CH;

  // Read-side state: IDLE while the vector FIFO is empty, SEND while a head entry is streamed.
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_t;
endpackage

// File: rtl/conv_2d_result_serializer_if.sv
// Channel-sum input and serialized beat output bundle of the result serializer.
// Handshake: a beat transfers on a rising edge where valid_out && ready_in; once
// valid_out rises it stays high with dataout/ch_idx/pix_addr stable until that
// transfer. valid_in is a one-cycle qualifier with no back-pressure.
interface conv_2d_result_serializer_if;
  import conv_pkg::*;

  logic [VEC_W-1:0]          data_in;
  logic                      valid_in;
  logic signed [bitsize-1:0] dataout;
  logic [CH_W-1:0]           ch_idx;
  logic [ADDR_W-1:0]         pix_addr;
  logic                      valid_out;
  logic                      ready_in;
  logic                      last_ch;
  logic                      frame_done;
  logic                      overflow;
  logic                      busy;

  // Producer/consumer side: drives the adder vector and downstream ready.
  modport master (
    output data_in, valid_in, ready_in,
    input  dataout, ch_idx, pix_addr, valid_out, last_ch, frame_done, overflow, busy
  );

  // Serializer side.
  modport slave (
    input  data_in, valid_in, ready_in,
    output dataout, ch_idx, pix_addr, valid_out, last_ch, frame_done, overflow, busy
  );
endinterface

// File: rtl/conv_2d_vec_fifo.sv
// Small synchronous FIFO of {pixel address, channel vector} entries. A push while
// full is taken when a pop happens in the same cycle; pops on empty are ignored.
module conv_2d_vec_fifo #(
  parameter  int WIDTH = 238,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/conv_2d_result_serializer.sv
// Buffers 16-channel sum vectors from the adder stage and streams them out one
// channel per beat, tagged with channel index and pixel address.
module conv_2d_result_serializer #(
  parameter int FIFO_DEPTH = conv_pkg::FIFO_DEPTH,
  parameter int NUM_PIXELS = conv_pkg::NUM_PIXELS
) (
  input  logic                      clk,
  input  logic                      rst,
  conv_2d_result_serializer_if.slave bus,
  output conv_pkg::rd_state_t       fsm_state
);
  import conv_pkg::*;

  localparam int ENT_W = VEC_W + ADDR_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  rd_state_t         state_q;
  rd_state_t         state_d;
  logic [CH_W-1:0]   ch_q;
  logic [ADDR_W-1:0] wr_pix_q;
  logic              overflow_q;
  logic              frame_done_q;

  logic [ENT_W-1:0]  fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  logic [VEC_W-1:0]  head_vec;
  logic [ADDR_W-1:0] head_addr;
  logic              valid_out;
  logic              is_last;
  logic              xfer;
  logic              pop;
  logic              push_ok;

  conv_2d_vec_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.valid_in),
    .pop   (pop),
    .wdata ({wr_pix_q, bus.data_in}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_vec  = fifo_rdata[VEC_W-1:0];
  assign head_addr = fifo_rdata[ENT_W-1:VEC_W];
  assign valid_out = (state_q == RD_SEND);
  assign is_last   = (ch_q == CH_W'(NUM_CH - 1));
  assign xfer      = valid_out && bus.ready_in;
  assign pop       = xfer && is_last;
  // Mirrors the FIFO's own accept rule so the pixel counter and overflow agree with it.
  assign push_ok   = bus.valid_in && (!fifo_full || pop);

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RD_IDLE;
    else     state_q <= state_d;
  end

  // Next state tracks FIFO occupancy: SEND exactly when an entry is at the head.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE: if (push_ok) state_d = RD_SEND;
      RD_SEND: if (pop && !push_ok && fifo_count == CNT_W'(1)) state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  // Channel counter advances per transfer and returns to 0 when the head pops.
  always_ff @(posedge clk) begin
    if (rst)       ch_q <= '0;
    else if (xfer) ch_q <= is_last ? '0 : ch_q + 1'b1;
  end

  // Write pixel counter advances only for accepted vectors and wraps per frame.
  always_ff @(posedge clk) begin
    if (rst)
      wr_pix_q <= '0;
    else if (push_ok)
      wr_pix_q <= (wr_pix_q == ADDR_W'(NUM_PIXELS - 1)) ? '0 : wr_pix_q + 1'b1;
  end

  // Sticky drop flag and registered end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (bus.valid_in && !push_ok) overflow_q <= 1'b1;
      frame_done_q <= pop && (head_addr == ADDR_W'(NUM_PIXELS - 1));
    end
  end

  assign bus.dataout    = valid_out ? head_vec[ch_q*bitsize +: bitsize] : '0;
  assign bus.pix_addr   = valid_out ? head_addr : '0;
  assign bus.ch_idx     = ch_q;
  assign bus.valid_out  = valid_out;
  assign bus.last_ch    = valid_out && is_last;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = !fifo_empty;
  assign fsm_state      = state_q;
endmodule

// File: tb/tb_conv_2d_result_serializer.sv
// Bench for the result serializer, built with a 4-pixel frame so wrap is reachable.
module tb_conv_2d_result_serializer;
  import conv_pkg::*;

  localparam int NP = 4;
  localparam int EW = ADDR_W + CH_W + bitsize;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  rd_state_t fsm_state;

  conv_2d_result_serializer_if bus();

  conv_2d_result_serializer #(
    .FIFO_DEPTH (2),
    .NUM_PIXELS (NP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [EW-1:0]     exp_q[$];
  logic [ADDR_W-1:0] exp_pix = '0;
  int n_cmp = 0;
  int n_err = 0;
  bit fd_pending = 1'b0;
  int fd_count = 0;

  logic [EW-1:0]     m_e;
  logic [CH_W-1:0]   m_ch;
  logic [ADDR_W-1:0] m_pix;

  // Scoreboard: every beat about to transfer at the next edge is popped and compared.
  always @(negedge clk) begin
    if (rst) begin
      fd_pending = 1'b0;
    end else begin
      if (fd_pending || bus.frame_done) begin
        n_cmp++;
        if (bus.frame_done !== fd_pending) begin
          n_err++;
          $display("FAIL frame_done: got %b want %b at %0t", bus.frame_done, fd_pending, $time);
        end
      end
      if (bus.frame_done === 1'b1) fd_count++;
      fd_pending = 1'b0;
      if (bus.valid_out && bus.ready_in) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got ch=%0d pix=%0d data=%h want none", bus.ch_idx, bus.pix_addr, bus.dataout);
        end else begin
          m_e   = exp_q.pop_front();
          m_ch  = m_e[bitsize +: CH_W];
          m_pix = m_e[bitsize+CH_W +: ADDR_W];
          if ({bus.pix_addr, bus.ch_idx, bus.dataout} !== m_e ||
              bus.last_ch !== (m_ch == CH_W'(NUM_CH - 1))) begin
            n_err++;
            $display("FAIL beat: got pix=%0d ch=%0d data=%h last=%b want pix=%0d ch=%0d data=%h last=%b",
                     bus.pix_addr, bus.ch_idx, bus.dataout, bus.last_ch,
                     m_pix, m_ch, m_e[bitsize-1:0], (m_ch == CH_W'(NUM_CH - 1)));
          end
          if (m_ch == CH_W'(NUM_CH - 1) && m_pix == ADDR_W'(NP - 1)) fd_pending = 1'b1;
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.valid_in = 1'b0;
    exp_q.delete();
    exp_pix = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int c = 0; c < NUM_CH; c++)
      v[c*bitsize +: bitsize] = bitsize'($urandom_range(0, (1 << bitsize) - 1));
    return v;
  endfunction

  // Drive one valid_in cycle; queue the expected beats when the vector should be kept.
  task automatic push_vec(input logic [VEC_W-1:0] v, input bit keep);
    bus.data_in  = v;
    bus.valid_in = 1'b1;
    if (keep) begin
      for (int c = 0; c < NUM_CH; c++)
        exp_q.push_back({exp_pix, CH_W'(c), v[c*bitsize +: bitsize]});
      exp_pix = (exp_pix == ADDR_W'(NP - 1)) ? '0 : exp_pix + 1'b1;
    end
    tick();
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    ok = (exp_q.size() == 0);
  endtask

  // Tests
  task automatic test_reset();
    bus.ready_in = 1'b1;
    do_reset();
    n_cmp++;
    if ({bus.valid_out, bus.busy, bus.last_ch, bus.overflow, bus.frame_done,
         bus.ch_idx, bus.dataout, bus.pix_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got vo=%b busy=%b last=%b ovf=%b fd=%b ch=%0d data=%h pix=%0d want all 0",
               bus.valid_out, bus.busy, bus.last_ch, bus.overflow, bus.frame_done,
               bus.ch_idx, bus.dataout, bus.pix_addr);
    end
    n_cmp++;
    if (fsm_state !== RD_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", fsm_state, RD_IDLE);
    end
  endtask

  task automatic test_single();
    logic [VEC_W-1:0] v;
    bit ok;
    do_reset();
    bus.ready_in = 1'b1;
    for (int c = 0; c < NUM_CH; c++) v[c*bitsize +: bitsize] = bitsize'(c - 8);
    push_vec(v, 1'b1);
    n_cmp++;
    if (bus.valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL single_latency: got valid_out=%b want 1", bus.valid_out);
    end
    wait_drain(40, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL single_drain: got %0d beats left want 0", exp_q.size());
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: got busy=%b valid_out=%b want 0 0", bus.busy, bus.valid_out);
    end
  endtask

  task automatic test_back_to_back();
    int high = 0;
    bit ok;
    do_reset();
    bus.ready_in = 1'b1;
    push_vec(rand_vec(), 1'b1);
    push_vec(rand_vec(), 1'b1);
    for (int i = 0; i < 31; i++) begin
      if (bus.valid_out === 1'b1) high++;
      tick();
    end
    n_cmp++;
    if (high != 31) begin
      n_err++;
      $display("FAIL b2b_no_bubble: got %0d valid cycles want 31", high);
    end
    wait_drain(10, ok);
    n_cmp++;
    if (!ok || bus.valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end: got left=%0d valid_out=%b want 0 0", exp_q.size(), bus.valid_out);
    end
  endtask

  task automatic test_backpressure();
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [ADDR_W+CH_W+bitsize:0] snap;
    bit stall;
    int k = 0;
    do_reset();
    bus.ready_in = 1'b0;
    push_vec(rand_vec(), 1'b1);
    push_vec(rand_vec(), 1'b1);
    while (exp_q.size() > 0 && k < 300) begin
      bus.ready_in = (k < 64) ? pat[k % 4] : 1'($urandom_range(0, 1));
      snap  = {bus.valid_out, bus.pix_addr, bus.ch_idx, bus.dataout};
      stall = bus.valid_out && !bus.ready_in;
      tick();
      if (stall) begin
        n_cmp++;
        if ({bus.valid_out, bus.pix_addr, bus.ch_idx, bus.dataout} !== snap) begin
          n_err++;
          $display("FAIL stall_hold: got %h want %h", {bus.valid_out, bus.pix_addr, bus.ch_idx, bus.dataout}, snap);
        end
      end
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_drain: got %0d beats left want 0", exp_q.size());
    end
    bus.ready_in = 1'b1;
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    bus.ready_in = 1'b0;
    push_vec(rand_vec(), 1'b1);
    tick();
    push_vec(rand_vec(), 1'b1);
    tick();
    n_cmp++;
    if (bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_early: got %b want 0", bus.overflow);
    end
    push_vec(rand_vec(), 1'b0);
    n_cmp++;
    if (bus.overflow !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set: got ovf=%b busy=%b want 1 1", bus.overflow, bus.busy);
    end
    bus.ready_in = 1'b1;
    wait_drain(60, ok);
    push_vec(rand_vec(), 1'b1);
    wait_drain(40, ok);
    n_cmp++;
    if (!ok || bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky: got left=%0d ovf=%b want 0 1", exp_q.size(), bus.overflow);
    end
  endtask

  task automatic test_push_pop_full();
    int n = 0;
    bit ok;
    do_reset();
    bus.ready_in = 1'b0;
    push_vec(rand_vec(), 1'b1);
    push_vec(rand_vec(), 1'b1);
    bus.ready_in = 1'b1;
    while (!(bus.valid_out === 1'b1 && bus.ch_idx == CH_W'(NUM_CH - 1)) && n < 40) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= 40) begin
      n_err++;
      $display("FAIL ppf_wait: got no last channel want one within 40 cycles");
    end
    push_vec(rand_vec(), 1'b1);
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL ppf_accept: got ovf=%b busy=%b want 0 1", bus.overflow, bus.busy);
    end
    wait_drain(60, ok);
    n_cmp++;
    if (!ok || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ppf_drain: got left=%0d ovf=%b want 0 0", exp_q.size(), bus.overflow);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    bus.ready_in = 1'b1;
    fd_count = 0;
    for (int v = 0; v < 5; v++) begin
      push_vec(rand_vec(), 1'b1);
      repeat (15) tick();
    end
    wait_drain(40, ok);
    tick();
    tick();
    n_cmp++;
    if (!ok || fd_count != 1) begin
      n_err++;
      $display("FAIL wrap_frame_done: got left=%0d pulses=%0d want 0 1", exp_q.size(), fd_count);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit ok;
    do_reset();
    bus.ready_in = 1'b0;
    push_vec(rand_vec(), 1'b1);
    push_vec(rand_vec(), 1'b1);
    push_vec(rand_vec(), 1'b0);
    bus.ready_in = 1'b1;
    while (!(bus.valid_out === 1'b1 && bus.ch_idx == CH_W'(7)) && n < 20) begin
      tick();
      n++;
    end
    rst = 1'b1;
    bus.data_in  = rand_vec();
    bus.valid_in = 1'b1;
    exp_q.delete();
    exp_pix = '0;
    tick();
    bus.valid_in = 1'b0;
    rst = 1'b0;
    n_cmp++;
    if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.ch_idx !== '0 || bus.dataout !== '0) begin
      n_err++;
      $display("FAIL rst_mid: got vo=%b busy=%b ovf=%b ch=%0d data=%h want 0 0 0 0 0",
               bus.valid_out, bus.busy, bus.overflow, bus.ch_idx, bus.dataout);
    end
    push_vec(rand_vec(), 1'b1);
    wait_drain(40, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL rst_mid_drain: got %0d beats left want 0", exp_q.size());
    end
  endtask

  // Sequence and report
  initial begin
    bus.data_in  = '0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_push_pop_full();
    test_wrap();
    test_reset_mid();
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
